key_sw_responder: RTL and testbench
===================================

// Module: key_sw_responder
// PURPOSE
//  Memory-mapped responder for the CPU data bus (M stage) serving KEY/SW input devices.
//  - Synchronizes and debounces KEY[3:0] and SW[9:0].
//  - Latches key-press and switch-change events into sticky Ready/Overrun status bits.
//  - Returns data/control words on bus reads.
//  - Raises per-device interrupt requests.
//  - Replaces the raw {~KEY}/{SW} read path at ADDRKEY/ADDRSW.
// PARAMETERS
//  ADDRKEY        32'hFFFFF080  key data reg; key ctrl at ADDRKEY+4
//  ADDRSW         32'hFFFFF090  switch data reg; switch ctrl at ADDRSW+4
//  DEBOUNCE_CYCLES 500000       stable cycles required before a debounced value changes (10 ms @ 50 MHz)
//  CNTBITS        20            debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk      in   1   system clock
//  RESET_N  in   1   asynchronous, active-low reset
//  abus     in   32  bus address (memaddr_M)
//  we       in   1   bus write strobe (wrmem_M)
//  re       in   1   bus read strobe; qualifies read side effects (selmemout_M & wrreg_M)
//  wdata    in   32  bus write data
//  rdata    out  32  read data, combinational from abus; 0 when hit=0
//  hit      out  1   abus matches one of the 4 registers
//  KEY      in   4   raw board keys, active-low
//  SW       in   10  raw board switches
//  irq_key  out  1   KCTRL.IE & KCTRL.Ready
//  irq_sw   out  1   SCTRL.IE & SCTRL.Ready
// BEHAVIOUR
//  Register map (rdata layout; unused bits read 0):
//   KDATA  ADDRKEY    [3:0]  debounced pressed keys (1 = pressed)
//   KCTRL  ADDRKEY+4  [0] Ready, [2] Overrun, [4] IE
//   SDATA  ADDRSW     [9:0]  debounced switches
//   SCTRL  ADDRSW+4   same layout as KCTRL
//  Per-input debounce:
//   - 2-FF synchronizer.
//   - Counter clears whenever sync == debounced and increments otherwise.
//   - When the count reaches DEBOUNCE_CYCLES-1 with sync != debounced, debounced <= sync on that edge.
//   - Latency raw->KDATA/SDATA = DEBOUNCE_CYCLES+2 cycles.
//   - A glitch shorter than DEBOUNCE_CYCLES is ignored.
//  Events:
//   - Key event = any debounced key 0->1 (press). Release sets nothing.
//   - Switch event = any debounced SW bit change.
//   - Ready is set one edge after the event (latency DEBOUNCE_CYCLES+3).
//   - Event while Ready=1 -> Overrun<=1.
//  Clears:
//   - re & abus==KDATA clears KCTRL.Ready on the edge; same for SDATA/SCTRL.
//   - Event and read-clear in the same cycle -> Ready stays 1 (set wins) and Overrun is not set.
//   - re=0 reads have no side effects.
//  Writes:
//   - KCTRL/SCTRL: IE<=wdata[4]; Overrun cleared if wdata[2]==0; Ready not writable.
//   - Writes to KDATA/SDATA are ignored.
//   - we & re together: write effects apply, read clear still applies.
//  Reset (async, RESET_N=0):
//   - sync/debounced KEY = 4'hF raw (0 pressed); SW sync/debounced = 0.
//   - Counters = 0; Ready = Overrun = IE = 0; irq_* = 0.
//   - Reset mid-debounce discards the partial count.
//   - SW held high through reset produces one switch event after DEBOUNCE_CYCLES+3 cycles.
// STRUCTURE
//  Shared package: register offsets, ctrl bit positions (READY=0, OVR=2, IE=4).
//  Sub-module debounce_bit (sync + counter + debounced FF, parameter IDLE):
//   - instantiated 4x with IDLE=1 for keys, 10x with IDLE=0 for switches.
//  Top level holds the edge detectors, status regs, address decode and read mux.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset, KEY=4'hF, SW=0 -> KDATA=0, KCTRL=0, SDATA=0, irq_key=irq_sw=0; abus=0 -> hit=0, rdata=0.
//  2. KEY[1]=0 held 10 cycles -> KDATA=4'h2 after 6 edges, KCTRL=1 after 7; then re read of KDATA -> KCTRL=0 next edge.
//  3. KEY[0]=0 for 3 cycles then 1 -> KDATA stays 0, KCTRL stays 0.
//  4. Write SCTRL=32'h10; toggle SW[9] twice without reading -> SCTRL=32'h15, irq_sw=1; write SCTRL=32'h10 -> 32'h11; re read SDATA -> 32'h10, irq_sw=0.
//  5. Key press event on the same edge as re read of KDATA -> KCTRL.Ready=1, Overrun=0.
//  6. RESET_N=0 at count 2 of a KEY[2] debounce -> all regs 0 immediately; release reset with KEY[2] still low -> KDATA=4'h4 after 6 edges.

Source files
------------

// File: rtl/key_sw_responder_pkg.sv
// Shared definitions for the KEY/SW bus responder: register offsets, control-word
// bit positions and the status-register update rule used by both devices.
package key_sw_responder_pkg;

    localparam logic [31:0] DATA_OFS = 32'h0;
    localparam logic [31:0] CTRL_OFS = 32'h4;

    localparam int READY_BIT = 0;
    localparam int OVR_BIT   = 2;
    localparam int IE_BIT    = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KDATA,
        SEL_KCTRL,
        SEL_SDATA,
        SEL_SCTRL
    } sel_e;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w            = '0;
        w[READY_BIT] = c.ready;
        w[OVR_BIT]   = c.ovr;
        w[IE_BIT]    = c.ie;
        return w;
    endfunction

    // A new event always wins over a same-cycle read-clear, and only counts as an
    // overrun when the previous event is still unacknowledged.
    function automatic ctrl_t next_ctrl(input ctrl_t cur, input logic evt, input logic clr,
                                        input logic wr, input logic ie_in, input logic ovr_keep);
        ctrl_t n;
        n = cur;
        if (wr) begin
            n.ie = ie_in;
            if (!ovr_keep) n.ovr = 1'b0;
        end
        if (clr) n.ready = 1'b0;
        if (evt) begin
            if (cur.ready && !clr) n.ovr = 1'b1;
            n.ready = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/key_sw_responder_if.sv
// CPU data-bus (M stage) view of the KEY/SW responder.
interface key_sw_responder_if;
    logic [31:0] abus;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output abus, we, re, wdata, input rdata, hit);
    modport slave  (input abus, we, re, wdata, output rdata, hit);
endinterface

// File: rtl/key_sw_responder_debounce_bit.sv
// One input bit: 2-FF synchronizer followed by a stability counter that only lets the
// debounced value follow the synchronized input after DEBOUNCE_CYCLES agreeing edges.
module debounce_bit #(
    parameter logic IDLE            = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNTBITS         = 20
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic raw,
    output logic deb
);

    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

    logic               sync1_q, sync2_q;
    logic               deb_q, deb_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) deb_d = sync2_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            deb_q   <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/key_sw_responder.sv
// Memory-mapped KEY/SW responder: debounced data registers, sticky Ready/Overrun
// status with interrupt enables, and a combinational read mux for the M-stage bus.
module key_sw_responder
    import key_sw_responder_pkg::*;
#(
    parameter logic [31:0] ADDRKEY         = 32'hFFFFF080,
    parameter logic [31:0] ADDRSW          = 32'hFFFFF090,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNTBITS         = 20
) (
    input  logic                clk,
    input  logic                RESET_N,
    key_sw_responder_if.slave   bus,
    input  logic [3:0]          KEY,
    input  logic [9:0]          SW,
    output logic                irq_key,
    output logic                irq_sw
);

    logic [3:0] key_deb, key_prs;
    logic [9:0] sw_deb;

    for (genvar i = 0; i < 4; i++) begin : g_key
        debounce_bit #(.IDLE(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)) u_db (
            .clk(clk), .RESET_N(RESET_N), .raw(KEY[i]), .deb(key_deb[i])
        );
    end

    for (genvar i = 0; i < 10; i++) begin : g_sw
        debounce_bit #(.IDLE(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)) u_db (
            .clk(clk), .RESET_N(RESET_N), .raw(SW[i]), .deb(sw_deb[i])
        );
    end

    // Keys are active-low on the board; everything past this point is "1 = pressed".
    assign key_prs = ~key_deb;

    logic [3:0] key_prs_q, key_prs_d;
    logic [9:0] sw_prev_q, sw_prev_d;
    ctrl_t      kctrl_q, kctrl_d;
    ctrl_t      sctrl_q, sctrl_d;
    sel_e       sel;
    logic       key_evt, sw_evt;
    logic       kclr, sclr, kwr, swr;
    logic       unused_wdata;

    always_comb begin
        sel = SEL_NONE;
        if      (bus.abus == ADDRKEY + DATA_OFS) sel = SEL_KDATA;
        else if (bus.abus == ADDRKEY + CTRL_OFS) sel = SEL_KCTRL;
        else if (bus.abus == ADDRSW  + DATA_OFS) sel = SEL_SDATA;
        else if (bus.abus == ADDRSW  + CTRL_OFS) sel = SEL_SCTRL;
    end

    always_comb begin
        bus.rdata = '0;
        case (sel)
            SEL_KDATA: bus.rdata = {28'b0, key_prs};
            SEL_KCTRL: bus.rdata = ctrl_word(kctrl_q);
            SEL_SDATA: bus.rdata = {22'b0, sw_deb};
            SEL_SCTRL: bus.rdata = ctrl_word(sctrl_q);
            default:   bus.rdata = '0;
        endcase
    end

    assign bus.hit = (sel != SEL_NONE);

    assign key_evt = |(key_prs & ~key_prs_q);
    assign sw_evt  = |(sw_deb ^ sw_prev_q);

    assign kclr = bus.re && (sel == SEL_KDATA);
    assign sclr = bus.re && (sel == SEL_SDATA);
    assign kwr  = bus.we && (sel == SEL_KCTRL);
    assign swr  = bus.we && (sel == SEL_SCTRL);

    assign unused_wdata = ^{bus.wdata[31:5], bus.wdata[3], bus.wdata[1:0]};

    always_comb begin
        key_prs_d = key_prs;
        sw_prev_d = sw_deb;
        kctrl_d   = next_ctrl(kctrl_q, key_evt, kclr, kwr, bus.wdata[IE_BIT], bus.wdata[OVR_BIT]);
        sctrl_d   = next_ctrl(sctrl_q, sw_evt,  sclr, swr, bus.wdata[IE_BIT], bus.wdata[OVR_BIT]);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            key_prs_q <= '0;
            sw_prev_q <= '0;
            kctrl_q   <= '0;
            sctrl_q   <= '0;
        end else begin
            key_prs_q <= key_prs_d;
            sw_prev_q <= sw_prev_d;
            kctrl_q   <= kctrl_d;
            sctrl_q   <= sctrl_d;
        end
    end

    assign irq_key = kctrl_q.ie & kctrl_q.ready;
    assign irq_sw  = sctrl_q.ie & sctrl_q.ready;

endmodule

// File: tb/tb_key_sw_responder.sv
// Bench for key_sw_responder with a short debounce window: reset-state register table,
// directed multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_key_sw_responder;

    localparam int          DC    = 4;
    localparam logic [31:0] AK    = 32'hFFFFF080;
    localparam logic [31:0] AS    = 32'hFFFFF090;
    localparam logic [31:0] KDATA = AK;
    localparam logic [31:0] KCTRL = AK + 32'h4;
    localparam logic [31:0] SDATA = AS;
    localparam logic [31:0] SCTRL = AS + 32'h4;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       irq_key, irq_sw;

    key_sw_responder_if bus();

    key_sw_responder #(
        .ADDRKEY(AK), .ADDRSW(AS), .DEBOUNCE_CYCLES(DC), .CNTBITS(20)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .bus(bus),
        .KEY(KEY), .SW(SW), .irq_key(irq_key), .irq_sw(irq_sw)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
        bus.abus  = a;
        bus.we    = w;
        bus.re    = r;
        bus.wdata = d;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        drive(a, 1'b0, 1'b0, 32'h0);
        #1;
        chk(nm, bus.rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, 1'b1, 1'b0, d);
        edges(1);
        drive(a, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rdclr(input logic [31:0] a);
        drive(a, 1'b0, 1'b1, 32'h0);
        edges(1);
        drive(a, 1'b0, 1'b0, 32'h0);
    endtask

    // Behavioural model: raw inputs reach the debouncer two edges late; a debounced bit
    // adopts that delayed value once it has disagreed for DC consecutive edges.
    logic [3:0] m_kraw1, m_kraw2, m_kdeb, m_kdeb_prev;
    logic [9:0] m_sraw1, m_sraw2, m_sdeb, m_sdeb_prev;
    int         m_kstr[4];
    int         m_sstr[10];
    logic       m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie;

    task automatic model_reset();
        m_kraw1 = 4'hF; m_kraw2 = 4'hF; m_kdeb = 4'hF; m_kdeb_prev = 4'hF;
        m_sraw1 = '0;   m_sraw2 = '0;   m_sdeb = '0;   m_sdeb_prev = '0;
        for (int i = 0; i < 4; i++)  m_kstr[i] = 0;
        for (int i = 0; i < 10; i++) m_sstr[i] = 0;
        {m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie} = '0;
    endtask

    task automatic model_step();
        logic kevt, sevt, kclr, sclr, kwr, swr;
        kevt = |(~m_kdeb & m_kdeb_prev);
        sevt = (m_sdeb != m_sdeb_prev);
        kclr = bus.re && (bus.abus == KDATA);
        sclr = bus.re && (bus.abus == SDATA);
        kwr  = bus.we && (bus.abus == KCTRL);
        swr  = bus.we && (bus.abus == SCTRL);

        if (kevt && m_krdy && !kclr)     m_kovr = 1'b1;
        else if (kwr && !bus.wdata[2])   m_kovr = 1'b0;
        m_krdy = kevt ? 1'b1 : (kclr ? 1'b0 : m_krdy);
        if (kwr) m_kie = bus.wdata[4];

        if (sevt && m_srdy && !sclr)     m_sovr = 1'b1;
        else if (swr && !bus.wdata[2])   m_sovr = 1'b0;
        m_srdy = sevt ? 1'b1 : (sclr ? 1'b0 : m_srdy);
        if (swr) m_sie = bus.wdata[4];

        m_kdeb_prev = m_kdeb;
        m_sdeb_prev = m_sdeb;
        for (int i = 0; i < 4; i++) begin
            if (m_kraw2[i] != m_kdeb[i]) begin
                m_kstr[i]++;
                if (m_kstr[i] == DC) begin m_kdeb[i] = m_kraw2[i]; m_kstr[i] = 0; end
            end else m_kstr[i] = 0;
        end
        for (int i = 0; i < 10; i++) begin
            if (m_sraw2[i] != m_sdeb[i]) begin
                m_sstr[i]++;
                if (m_sstr[i] == DC) begin m_sdeb[i] = m_sraw2[i]; m_sstr[i] = 0; end
            end else m_sstr[i] = 0;
        end
        m_kraw2 = m_kraw1; m_kraw1 = KEY;
        m_sraw2 = m_sraw1; m_sraw1 = SW;
    endtask

    function automatic logic [32:0] model_read(input logic [31:0] a);
        if (a == KDATA) return {1'b1, 28'b0, ~m_kdeb};
        if (a == KCTRL) return {1'b1, 27'b0, m_kie, 1'b0, m_kovr, 1'b0, m_krdy};
        if (a == SDATA) return {1'b1, 22'b0, m_sdeb};
        if (a == SCTRL) return {1'b1, 27'b0, m_sie, 1'b0, m_sovr, 1'b0, m_srdy};
        return 33'b0;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } rd_vec_t;

    rd_vec_t tbl[7];

    initial begin
        logic [32:0] exp;
        tbl[0] = '{32'h0,        1'b0, 32'h0};
        tbl[1] = '{KDATA,        1'b1, 32'h0};
        tbl[2] = '{KCTRL,        1'b1, 32'h0};
        tbl[3] = '{SDATA,        1'b1, 32'h0};
        tbl[4] = '{SCTRL,        1'b1, 32'h0};
        tbl[5] = '{AK + 32'h8,   1'b0, 32'h0};
        tbl[6] = '{AS - 32'h4,   1'b0, 32'h0};

        RESET_N = 1'b0;
        KEY = 4'hF;
        SW  = '0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        edges(2);
        RESET_N = 1'b1;

        // Reset state of every register and of the miss path
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].addr, 1'b0, 1'b0, 32'h0);
            #1;
            chk($sformatf("reset_hit[%0d]", i), {31'b0, bus.hit}, {31'b0, tbl[i].exp_hit});
            chk($sformatf("reset_rdata[%0d]", i), bus.rdata, tbl[i].exp_rdata);
        end
        chk("reset_irq_key", {31'b0, irq_key}, 32'h0);
        chk("reset_irq_sw",  {31'b0, irq_sw},  32'h0);

        // KEY[1] press: data after 6 edges, Ready after 7, read-clear on KDATA
        KEY = 4'hD;
        edges(5); rd(KDATA, 32'h0, "kdata_edge5");
        edges(1); rd(KDATA, 32'h2, "kdata_edge6");
        rd(KCTRL, 32'h0, "kctrl_edge6");
        edges(1); rd(KCTRL, 32'h1, "kctrl_edge7");
        chk("irq_key_ie0", {31'b0, irq_key}, 32'h0);
        rdclr(KDATA);
        rd(KCTRL, 32'h0, "kctrl_after_clr");
        edges(2);
        KEY = 4'hF;
        edges(8);
        rd(KDATA, 32'h0, "kdata_release");
        rd(KCTRL, 32'h0, "kctrl_release");

        // Three-cycle glitch on KEY[0] is filtered
        KEY = 4'hE;
        edges(3);
        KEY = 4'hF;
        edges(8);
        rd(KDATA, 32'h0, "kdata_glitch");
        rd(KCTRL, 32'h0, "kctrl_glitch");

        // Switch events, overrun, IE, write-clear of Overrun, read-clear of Ready
        wr(SCTRL, 32'h10);
        rd(SCTRL, 32'h10, "sctrl_ie");
        SW = 10'h200;
        edges(7);
        rd(SCTRL, 32'h11, "sctrl_first_evt");
        rd(SDATA, 32'h200, "sdata_sw9");
        chk("irq_sw_on", {31'b0, irq_sw}, 32'h1);
        SW = 10'h000;
        edges(7);
        rd(SCTRL, 32'h15, "sctrl_overrun");
        chk("irq_sw_ovr", {31'b0, irq_sw}, 32'h1);
        rd(SDATA, 32'h0, "sdata_re0");
        edges(1);
        rd(SCTRL, 32'h15, "sctrl_re0_no_clear");
        wr(SCTRL, 32'h10);
        rd(SCTRL, 32'h11, "sctrl_ovr_cleared");
        rdclr(SDATA);
        rd(SCTRL, 32'h10, "sctrl_ready_cleared");
        chk("irq_sw_off", {31'b0, irq_sw}, 32'h0);

        // Press event on the same edge as a KDATA read-clear while Ready is already set
        KEY = 4'h7;
        edges(7);
        rd(KCTRL, 32'h1, "kctrl_key3");
        KEY = 4'hF;
        edges(8);
        rd(KCTRL, 32'h1, "kctrl_release_no_evt");
        KEY = 4'hB;
        edges(6);
        drive(KDATA, 1'b0, 1'b1, 32'h0);
        edges(1);
        rd(KCTRL, 32'h1, "kctrl_set_wins");
        rd(KDATA, 32'h4, "kdata_key2");

        // Reset in the middle of a KEY[2] debounce
        KEY = 4'hF;
        edges(8);
        KEY = 4'hB;
        edges(4);
        RESET_N = 1'b0;
        rd(KCTRL, 32'h0, "kctrl_async_rst");
        rd(SCTRL, 32'h0, "sctrl_async_rst");
        rd(KDATA, 32'h0, "kdata_async_rst");
        chk("irq_key_rst", {31'b0, irq_key}, 32'h0);
        edges(1);
        RESET_N = 1'b1;
        edges(5); rd(KDATA, 32'h0, "kdata_post_rst5");
        edges(1); rd(KDATA, 32'h4, "kdata_post_rst6");

        // Randomized traffic against the model, starting from a reset with inputs active
        RESET_N = 1'b0;
        KEY = 4'($urandom);
        SW  = 10'($urandom) | 10'h001;
        model_reset();
        edges(2);
        RESET_N = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(9) == 0) KEY = KEY ^ (4'b1 << $urandom_range(3));
            if ($urandom_range(9) == 0) SW  = SW ^ (10'b1 << $urandom_range(9));
            case ($urandom_range(4))
                0:       bus.abus = KDATA;
                1:       bus.abus = KCTRL;
                2:       bus.abus = SDATA;
                3:       bus.abus = SCTRL;
                default: bus.abus = $urandom;
            endcase
            bus.re    = ($urandom_range(3) == 0);
            bus.we    = ($urandom_range(5) == 0);
            bus.wdata = $urandom;
            #1;
            exp = model_read(bus.abus);
            chk("rnd_hit",   {31'b0, bus.hit}, {31'b0, exp[32]});
            chk("rnd_rdata", bus.rdata, exp[31:0]);
            chk("rnd_irq_key", {31'b0, irq_key}, {31'b0, m_kie & m_krdy});
            chk("rnd_irq_sw",  {31'b0, irq_sw},  {31'b0, m_sie & m_srdy});
            model_step();
            edges(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
